bp_fe_scan_redirect: RTL and testbench

Consumer end of the front-end instruction-scan interface. Accepts one (PC, 43-bit scan packet) per cycle from the scanner, computes the control-flow target and a static BTFN prediction, and presents the result through a two-stage valid/yumi pipeline to the PC-generation logic. It also keeps a saturating count of predicted-taken redirects for performance monitoring.

---
 rtl/bp_fe_scan_redirect.sv | 163 ++++++++++++++++
 tb/tb_bp_fe_scan_redirect.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_scan_redirect.sv
// Scan-packet consumer: decodes the class, computes the branch target and BTFN prediction, counts consumed redirects.
// Two-entry valid/yumi pipe (A then B). A result appears 2 cycles after input. ready_o drops only when both stages are full and yumi_i is low.
module bp_fe_scan_redirect #(
  parameter int vaddr_width_p = 39,
  localparam int scan_width_p = 43
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     flush_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic [vaddr_width_p-1:0] pc_i,
  input  logic [scan_width_p-1:0]  scan_i,
  output logic                     v_o,
  input  logic                     yumi_i,
  output logic [vaddr_width_p-1:0] pc_o,
  output logic [1:0]               class_o,
  output logic [vaddr_width_p-1:0] target_pc_o,
  output logic                     taken_o,
  output logic                     target_unknown_o,
  output logic [vaddr_width_p-1:0] next_pc_o,
  output logic [15:0]              redirect_cnt_o
);

  typedef enum logic [1:0] {
    cls_none   = 2'b00,
    cls_jal    = 2'b01,
    cls_jalr   = 2'b10,
    cls_branch = 2'b11
  } cls_e;

  logic                     va;
  logic [vaddr_width_p-1:0] a_pc;
  logic [1:0]               a_class;
  logic [37:0]              a_field;

  logic                     vb;
  logic [vaddr_width_p-1:0] b_pc;
  logic [1:0]               b_class;
  logic [vaddr_width_p-1:0] b_target;
  logic [vaddr_width_p-1:0] b_next;
  logic                     b_taken;
  logic                     b_unknown;

  logic [15:0] cnt;

  logic adv_b;
  logic ready;
  logic accept;
  logic move;
  logic unused_rsvd;

  assign adv_b  = ~vb | yumi_i;
  assign ready  = ~va | adv_b;
  assign accept = v_i & ready;
  assign move   = va & adv_b;

  // Reserved scan bits carry no information for this consumer.
  assign unused_rsvd = ^scan_i[4:2];

  logic signed [38:0]       off39;
  logic [vaddr_width_p-1:0] off_ext;
  logic [vaddr_width_p-1:0] seq_pc;
  logic [vaddr_width_p-1:0] jump_pc;
  logic [vaddr_width_p-1:0] tgt;
  logic [vaddr_width_p-1:0] nxt;
  logic                     tk;
  logic                     unk;

  assign off39   = {a_field, 1'b0};
  assign off_ext = vaddr_width_p'(off39);
  assign seq_pc  = a_pc + vaddr_width_p'(4);
  assign jump_pc = a_pc + off_ext;

  always_comb begin
    tgt = seq_pc;
    tk  = 1'b0;
    unk = 1'b0;
    case (cls_e'(a_class))
      cls_branch: begin
        tgt = jump_pc;
        tk  = a_field[37];
      end
      cls_jal: begin
        tgt = jump_pc;
        tk  = 1'b1;
      end
      cls_jalr: begin
        tk  = 1'b1;
        unk = 1'b1;
      end
      default: ;
    endcase
  end

  // A JALR target is resolved later, so its fall-through is tgt (seq_pc) as well.
  assign nxt = tk ? tgt : seq_pc;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      va      <= 1'b0;
      a_pc    <= '0;
      a_class <= '0;
      a_field <= '0;
    end else begin
      if (flush_i)
        va <= 1'b0;
      else if (accept)
        va <= 1'b1;
      else if (move)
        va <= 1'b0;
      if (accept) begin
        a_pc    <= pc_i;
        a_class <= scan_i[1:0];
        a_field <= scan_i[42:5];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      vb        <= 1'b0;
      b_pc      <= '0;
      b_class   <= '0;
      b_target  <= '0;
      b_next    <= '0;
      b_taken   <= 1'b0;
      b_unknown <= 1'b0;
    end else begin
      if (flush_i)
        vb <= 1'b0;
      else if (adv_b)
        vb <= va;
      if (move) begin
        b_pc      <= a_pc;
        b_class   <= a_class;
        b_target  <= tgt;
        b_next    <= nxt;
        b_taken   <= tk;
        b_unknown <= unk;
      end
    end
  end

  // Counts consumption, so a yumi in a flush cycle still registers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)
      cnt <= '0;
    else if (vb && yumi_i && b_taken && cnt != 16'hFFFF)
      cnt <= cnt + 16'd1;
  end

  assign v_o              = vb & reset_n_i;
  assign ready_o          = ready | ~reset_n_i;
  assign pc_o             = reset_n_i ? b_pc : '0;
  assign class_o          = reset_n_i ? b_class : 2'b00;
  assign target_pc_o      = reset_n_i ? b_target : '0;
  assign next_pc_o        = reset_n_i ? b_next : '0;
  assign taken_o          = b_taken & reset_n_i;
  assign target_unknown_o = b_unknown & reset_n_i;
  assign redirect_cnt_o   = reset_n_i ? cnt : 16'h0000;

endmodule

// File: tb/tb_bp_fe_scan_redirect.sv
// Directed and random stimulus against a queue-based reference model of bp_fe_scan_redirect.
module tb_bp_fe_scan_redirect;
  localparam longint MASK = 64'h7F_FFFF_FFFF;

  logic        clk_i = 1'b0;
  logic        reset_n_i, flush_i, v_i, yumi_i;
  logic        ready_o, v_o, taken_o, target_unknown_o;
  logic [38:0] pc_i, pc_o, target_pc_o, next_pc_o;
  logic [42:0] scan_i;
  logic [1:0]  class_o;
  logic [15:0] redirect_cnt_o;

  always #5 clk_i = ~clk_i;

  bp_fe_scan_redirect dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i), .v_i(v_i), .ready_o(ready_o),
    .pc_i(pc_i), .scan_i(scan_i), .v_o(v_o), .yumi_i(yumi_i), .pc_o(pc_o), .class_o(class_o),
    .target_pc_o(target_pc_o), .taken_o(taken_o), .target_unknown_o(target_unknown_o),
    .next_pc_o(next_pc_o), .redirect_cnt_o(redirect_cnt_o)
  );

  typedef struct { logic [38:0] pc; logic [42:0] scan; int e_acc; } ent_t;
  typedef struct packed { logic [38:0] tgt; logic [38:0] nxt; logic tk; logic unk; } res_t;

  ent_t q[$];
  int   edge_n = 0;
  int   cnt_m = 0;
  int   total = 0;
  int   passed = 0;
  int   fails = 0;
  logic last_acc, last_cons;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [42:0] mk(input logic [1:0] cls, input longint field);
    logic [63:0] f;
    f = field;
    return {f[37:0], 3'b000, cls};
  endfunction

  // Reference: byte offset = 2 * signed halfword field, all sums modulo 2^39.
  function automatic res_t model(input logic [38:0] pc, input logic [42:0] scan);
    res_t   r;
    longint f, seq, jmp;
    f   = longint'($signed(scan[42:5]));
    seq = (longint'(pc) + 4) & MASK;
    jmp = (longint'(pc) + 2 * f) & MASK;
    r.unk = 1'b0;
    case (scan[1:0])
      2'b11: begin r.tk = scan[42]; r.tgt = jmp[38:0]; end
      2'b01: begin r.tk = 1'b1;     r.tgt = jmp[38:0]; end
      2'b10: begin r.tk = 1'b1;     r.tgt = seq[38:0]; r.unk = 1'b1; end
      default: begin r.tk = 1'b0;   r.tgt = seq[38:0]; end
    endcase
    r.nxt = (r.tk && !r.unk) ? r.tgt : seq[38:0];
    return r;
  endfunction

  // One clock cycle: drive, check against the model, clock, update the model.
  task automatic step(input logic v, input logic [38:0] pc, input logic [42:0] scan,
                      input logic yumi, input logic fl, input logic rn);
    logic vo_e, rdy_e;
    res_t r;
    r = '0;
    vo_e  = rn && q.size() > 0 && q[0].e_acc < edge_n;
    rdy_e = !rn || q.size() < 2 || (yumi && vo_e);
    v_i = v; pc_i = pc; scan_i = scan; yumi_i = yumi && vo_e; flush_i = fl; reset_n_i = rn;
    #1;
    chk("ready_o", ready_o, rdy_e);
    chk("v_o", v_o, vo_e);
    chk("redirect_cnt_o", redirect_cnt_o, rn ? cnt_m : 0);
    if (!rn) begin
      chk("rst_pc_o", pc_o, 0);
      chk("rst_target_pc_o", target_pc_o, 0);
      chk("rst_next_pc_o", next_pc_o, 0);
      chk("rst_taken_o", taken_o, 0);
    end else if (vo_e) begin
      r = model(q[0].pc, q[0].scan);
      chk("pc_o", pc_o, q[0].pc);
      chk("class_o", class_o, q[0].scan[1:0]);
      chk("target_pc_o", target_pc_o, r.tgt);
      chk("next_pc_o", next_pc_o, r.nxt);
      chk("taken_o", taken_o, r.tk);
      chk("target_unknown_o", target_unknown_o, r.unk);
    end
    last_acc  = v && rdy_e && rn;
    last_cons = yumi_i;
    @(posedge clk_i);
    edge_n++;
    if (!rn) begin
      q.delete();
      cnt_m = 0;
    end else begin
      if (last_cons && r.tk && cnt_m < 65535) cnt_m++;
      if (fl) q.delete();
      else begin
        if (last_cons) void'(q.pop_front());
        if (last_acc) q.push_back('{pc, scan, edge_n});
      end
    end
    #1;
  endtask

  task automatic idle(input logic yumi);
    step(1'b0, '0, '0, yumi, 1'b0, 1'b1);
  endtask

  // Single packet through an empty pipe, checked against hand-derived constants.
  task automatic one(input string tag, input logic [38:0] pc, input logic [42:0] scan,
                     input logic [38:0] e_tgt, input logic [38:0] e_nxt, input logic e_tk, input logic e_unk);
    step(1'b1, pc, scan, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk({tag, "_v"}, v_o, 1);
    chk({tag, "_tgt"}, target_pc_o, e_tgt);
    chk({tag, "_nxt"}, next_pc_o, e_nxt);
    chk({tag, "_tk"}, taken_o, e_tk);
    chk({tag, "_unk"}, target_unknown_o, e_unk);
    idle(1'b1);
  endtask

  initial begin
    int idx, outs;
    logic [38:0] rpc;
    logic [42:0] rscan;

    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_ready", ready_o, 1);
    chk("post_reset_v_o", v_o, 0);

    one("beq_back", 39'h80000010, mk(2'b11, -2), 39'h8000000C, 39'h8000000C, 1'b1, 1'b0);
    chk("beq_class", class_o, 2'b11);
    one("br_fwd", 39'h2000, mk(2'b11, 4), 39'h2008, 39'h2004, 1'b0, 1'b0);
    one("jal", 39'h1000, mk(2'b01, 'h400), 39'h1800, 39'h1800, 1'b1, 1'b0);
    one("jalr", 39'h3000, mk(2'b10, 'h55), 39'h3004, 39'h3004, 1'b1, 1'b1);
    one("jal_wrap", 39'h7F_FFFF_FFFC, mk(2'b01, 4), 39'h4, 39'h4, 1'b1, 1'b0);
    one("none", 39'h4440, mk(2'b00, 'h10), 39'h4444, 39'h4444, 1'b0, 1'b0);

    // Backpressure: 4 cycles of offered input with no yumi, then drain all six.
    idx = 0;
    outs = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 39'h5000 + 39'(idx * 4), mk(2'b01, idx + 1), 1'b0, 1'b0, 1'b1);
      if (last_acc) idx++;
    end
    chk("bp_accepted", idx, 2);
    chk("bp_ready_low", ready_o, 0);
    for (int c = 0; c < 20 && outs < 6; c++) begin
      step(idx < 6, 39'h5000 + 39'(idx * 4), mk(2'b01, idx + 1), 1'b1, 1'b0, 1'b1);
      if (last_acc) idx++;
      if (last_cons) outs++;
    end
    chk("bp_outputs", outs, 6);
    chk("bp_inputs", idx, 6);

    // Flush with both stages full and a handshake in the same cycle.
    step(1'b1, 39'h6000, mk(2'b01, 8), 1'b0, 1'b0, 1'b1);
    step(1'b1, 39'h6004, mk(2'b01, 8), 1'b0, 1'b0, 1'b1);
    step(1'b1, 39'h6008, mk(2'b01, 8), 1'b1, 1'b1, 1'b1);
    chk("flush_v_o", v_o, 0);
    idle(1'b1);
    idle(1'b1);

    for (int c = 0; c < 2000; c++) begin
      rpc   = 39'({$urandom, $urandom});
      rscan = mk(2'($urandom), longint'({$urandom, $urandom}));
      step($urandom_range(3, 0) != 0, rpc, rscan, $urandom_range(2, 0) != 0,
           $urandom_range(39, 0) == 0, $urandom_range(299, 0) != 0);
    end

    // Reset mid-stream.
    step(1'b1, 39'h7000, mk(2'b01, 2), 1'b0, 1'b0, 1'b1);
    step(1'b1, 39'h7004, mk(2'b01, 2), 1'b0, 1'b0, 1'b1);
    step(1'b1, 39'h7008, mk(2'b01, 2), 1'b1, 1'b0, 1'b0);
    chk("midrst_v_o", v_o, 0);
    chk("midrst_cnt", redirect_cnt_o, 0);
    chk("midrst_ready", ready_o, 1);

    // Counter saturation: 0x10002 taken JALs at full throughput.
    for (int c = 0; c < 'h10004; c++)
      step(c < 'h10002, 39'h9000, mk(2'b01, 16), 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("cnt_saturated", redirect_cnt_o, 16'hFFFF);
    one("nt_after_sat", 39'hA000, mk(2'b11, 6), 39'hA00C, 39'hA004, 1'b0, 1'b0);
    chk("cnt_hold", redirect_cnt_o, 16'hFFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
